// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths and defaults for the hazard scoreboard and its match encoder.
package hazard_scoreboard_pkg;

    localparam int WIDTH_T      = 3;
    localparam int DST_W        = 5;
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // Track entry layout: {v, dst, tnew}
    localparam int TRK_V_W    = 1;
    localparam int TRK_DST_W  = DST_W;
    localparam int TRK_TNEW_W = WIDTH_T;
    localparam int TRK_W      = TRK_V_W + TRK_DST_W + TRK_TNEW_W;

    // All-ones Tuse means the operand is never read early enough to stall.
    localparam logic [WIDTH_T-1:0] TUSE_INF = '1;

    // Index width for an n-entry table; a single entry still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Youngest-producer priority encoder over the post-ID track entries.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int T_WIDTH    = WIDTH_T,
    parameter int IDX_W      = idx_w(NUM_STAGES)
) (
    input  logic [NUM_STAGES-1:0]              trk_v,
    input  logic [NUM_STAGES-1:0][DST_W-1:0]   trk_dst,
    input  logic [NUM_STAGES-1:0][T_WIDTH-1:0] trk_tnew,
    input  logic [DST_W-1:0]                   addr,
    output logic                               hit,
    output logic [IDX_W-1:0]                   index,
    output logic [T_WIDTH-1:0]                 tnew
);

    // Scan oldest to youngest so the lowest matching index wins; r0 never matches.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        tnew  = '0;
        if (addr != '0) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (trk_v[k] && (trk_dst[k] == addr)) begin
                    hit   = 1'b1;
                    index = IDX_W'(k);
                    tnew  = trk_tnew[k];
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks pending writers per post-ID stage,
// derives stall/bubble/flush/forward controls and owns the mult/div busy counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int T_WIDTH    = WIDTH_T,
    parameter int MULT_LAT   = MULT_LAT_DEF,
    parameter int DIV_LAT    = DIV_LAT_DEF,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [DST_W-1:0]   id_rs,
    input  logic [DST_W-1:0]   id_rt,
    input  logic [T_WIDTH-1:0] id_tuse_rs,
    input  logic [T_WIDTH-1:0] id_tuse_rt,
    input  logic [DST_W-1:0]   id_dst,
    input  logic [T_WIDTH-1:0] id_tnew,
    input  logic               id_is_md,
    input  logic               id_md_start,
    input  logic               id_md_div,
    input  logic               flush_req,
    output logic               stall,
    output logic               clr_ex,
    output logic               clr_front,
    output logic               md_dis,
    output logic               md_busy,
    output logic [SEL_W-1:0]   fwd_sel_rs,
    output logic [SEL_W-1:0]   fwd_sel_rt
);

    localparam int IDX_W  = idx_w(NUM_STAGES);
    localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNT_W  = $clog2(MD_MAX + 1);
    localparam logic [T_WIDTH-1:0] TUSE_ALL1 = '1;

    logic [NUM_STAGES-1:0]              trk_v;
    logic [NUM_STAGES-1:0][DST_W-1:0]   trk_dst;
    logic [NUM_STAGES-1:0][T_WIDTH-1:0] trk_tnew;
    logic [CNT_W-1:0]                   md_cnt;

    logic               hit_rs, hit_rt;
    logic [IDX_W-1:0]   idx_rs, idx_rt;
    logic [T_WIDTH-1:0] tnew_rs, tnew_rt;
    logic               stall_rs, stall_rt, stall_md;

    function automatic logic [T_WIDTH-1:0] dec_sat(input logic [T_WIDTH-1:0] t);
        return (t == '0) ? '0 : t - T_WIDTH'(1);
    endfunction

    hazard_match #(.NUM_STAGES(NUM_STAGES), .T_WIDTH(T_WIDTH), .IDX_W(IDX_W)) u_match_rs (
        .trk_v    (trk_v),
        .trk_dst  (trk_dst),
        .trk_tnew (trk_tnew),
        .addr     (id_rs),
        .hit      (hit_rs),
        .index    (idx_rs),
        .tnew     (tnew_rs)
    );

    hazard_match #(.NUM_STAGES(NUM_STAGES), .T_WIDTH(T_WIDTH), .IDX_W(IDX_W)) u_match_rt (
        .trk_v    (trk_v),
        .trk_dst  (trk_dst),
        .trk_tnew (trk_tnew),
        .addr     (id_rt),
        .hit      (hit_rt),
        .index    (idx_rt),
        .tnew     (tnew_rt)
    );

    // A producer stalls its consumer only while its result is further away than the consumer's Tuse.
    always_comb begin
        stall_rs   = id_valid && hit_rs && (id_tuse_rs != TUSE_ALL1) && (tnew_rs > id_tuse_rs);
        stall_rt   = id_valid && hit_rt && (id_tuse_rt != TUSE_ALL1) && (tnew_rt > id_tuse_rt);
        stall_md   = md_busy && id_is_md && id_valid;
        stall      = !flush_req && (stall_rs || stall_rt || stall_md);
        clr_ex     = stall || flush_req;
        clr_front  = flush_req;
        md_dis     = flush_req;
        fwd_sel_rs = hit_rs ? SEL_W'(idx_rs) + SEL_W'(1) : '0;
        fwd_sel_rt = hit_rt ? SEL_W'(idx_rt) + SEL_W'(1) : '0;
    end

    assign md_busy = (md_cnt != '0);

    // Shift the track one stage per cycle, ageing every entry; a stall shifts in a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trk_v    <= '0;
            trk_dst  <= '0;
            trk_tnew <= '0;
        end else if (flush_req) begin
            trk_v <= '0;
        end else begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                trk_v[k]    <= trk_v[k-1];
                trk_dst[k]  <= trk_dst[k-1];
                trk_tnew[k] <= dec_sat(trk_tnew[k-1]);
            end
            if (stall) begin
                trk_v[0]    <= 1'b0;
                trk_dst[0]  <= '0;
                trk_tnew[0] <= '0;
            end else begin
                trk_v[0]    <= id_valid && (id_dst != '0);
                trk_dst[0]  <= id_dst;
                trk_tnew[0] <= dec_sat(id_tnew);
            end
        end
    end

    // Mult/div busy down-counter; a flush leaves an in-flight op running but blocks a new start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt <= '0;
        end else if (id_valid && id_md_start && !stall && !flush_req) begin
            md_cnt <= id_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a producer-list reference model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NS = 4;
    localparam int TW = 3;
    localparam int ML = 5;
    localparam int DL = 10;
    localparam int SW = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          id_valid;
    logic [4:0]    id_rs, id_rt, id_dst;
    logic [TW-1:0] id_tuse_rs, id_tuse_rt, id_tnew;
    logic          id_is_md, id_md_start, id_md_div, flush_req;
    logic          stall, clr_ex, clr_front, md_dis, md_busy;
    logic [SW-1:0] fwd_sel_rs, fwd_sel_rt;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.NUM_STAGES(NS), .T_WIDTH(TW), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_tuse_rs  (id_tuse_rs),
        .id_tuse_rt  (id_tuse_rt),
        .id_dst      (id_dst),
        .id_tnew     (id_tnew),
        .id_is_md    (id_is_md),
        .id_md_start (id_md_start),
        .id_md_div   (id_md_div),
        .flush_req   (flush_req),
        .stall       (stall),
        .clr_ex      (clr_ex),
        .clr_front   (clr_front),
        .md_dis      (md_dis),
        .md_busy     (md_busy),
        .fwd_sel_rs  (fwd_sel_rs),
        .fwd_sel_rt  (fwd_sel_rt)
    );

    always #5 clk = ~clk;

    // Reference model: a list of issued producers stamped with their issue cycle.
    typedef struct {
        logic [4:0] dst;
        int         tnew_id;
        int         issue;
        bit         live;
    } prod_t;

    prod_t q[$];
    int    cyc     = 0;
    int    md_last = -1;

    function automatic void model_match(input logic [4:0] a, output bit hit,
                                        output int pos, output int rem);
        int best;
        int age;
        hit  = 1'b0;
        pos  = 0;
        rem  = 0;
        best = -1;
        if (a != 5'd0) begin
            foreach (q[i]) begin
                age = cyc - q[i].issue;
                if (q[i].live && q[i].dst == a && age >= 1 && age <= NS && q[i].issue > best) begin
                    best = q[i].issue;
                    hit  = 1'b1;
                    pos  = age - 1;
                    rem  = (q[i].tnew_id > age) ? q[i].tnew_id - age : 0;
                end
            end
        end
    endfunction

    function automatic void model_eval(output bit st, output int s_rs, output int s_rt,
                                       output bit busy);
        bit h_rs, h_rt, d_rs, d_rt;
        int p_rs, p_rt, r_rs, r_rt;
        busy = (cyc <= md_last);
        model_match(id_rs, h_rs, p_rs, r_rs);
        model_match(id_rt, h_rt, p_rt, r_rt);
        d_rs = id_valid && h_rs && (int'(id_tuse_rs) != 7) && (r_rs > int'(id_tuse_rs));
        d_rt = id_valid && h_rt && (int'(id_tuse_rt) != 7) && (r_rt > int'(id_tuse_rt));
        s_rs = h_rs ? p_rs + 1 : 0;
        s_rt = h_rt ? p_rt + 1 : 0;
        st   = !flush_req && (d_rs || d_rt || (busy && id_is_md && id_valid));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model on each edge using the inputs presented that cycle.
    always @(posedge clk or negedge reset_n) begin
        bit st, busy;
        int a, b;
        if (!reset_n) begin
            q.delete();
            cyc     = 0;
            md_last = -1;
        end else begin
            model_eval(st, a, b, busy);
            if (flush_req) begin
                foreach (q[i]) q[i].live = 1'b0;
            end else if (!st && id_valid && id_dst != 5'd0) begin
                q.push_back('{id_dst, int'(id_tnew), cyc, 1'b1});
            end
            if (id_valid && id_md_start && !st && !flush_req)
                md_last = cyc + (id_md_div ? DL : ML);
            cyc++;
            while (q.size() > 0 && cyc - q[0].issue > NS) void'(q.pop_front());
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        bit st, busy;
        int s_rs, s_rt;
        model_eval(st, s_rs, s_rt, busy);
        chk("m_stall",     32'(stall),      32'(st));
        chk("m_clr_ex",    32'(clr_ex),     32'(st || flush_req));
        chk("m_clr_front", 32'(clr_front),  32'(flush_req));
        chk("m_md_dis",    32'(md_dis),     32'(flush_req));
        chk("m_md_busy",   32'(md_busy),    32'(busy));
        chk("m_fwd_rs",    32'(fwd_sel_rs), 32'(s_rs));
        chk("m_fwd_rt",    32'(fwd_sel_rt), 32'(s_rt));
    end

    task automatic idle();
        id_valid    = 1'b0;
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_tuse_rs  = 3'd7;
        id_tuse_rt  = 3'd7;
        id_dst      = 5'd0;
        id_tnew     = 3'd0;
        id_is_md    = 1'b0;
        id_md_start = 1'b0;
        id_md_div   = 1'b0;
        flush_req   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic producer(input logic [4:0] dst, input logic [TW-1:0] tnew);
        idle();
        id_valid = 1'b1;
        id_dst   = dst;
        id_tnew  = tnew;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        mid();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_busy",  32'(md_busy), 0);
        chk("rst_fwd",   32'(fwd_sel_rs), 0);
        tick();

        // Load-use: lw r8 (tnew 3) then addu using r8 at Tuse 1
        producer(5'd8, 3'd3);
        id_tuse_rs = 3'd7;
        tick();
        producer(5'd9, 3'd1);
        id_rs = 5'd8;
        id_tuse_rs = 3'd1;
        mid();
        chk("lu_stall",  32'(stall), 1);
        chk("lu_clr_ex", 32'(clr_ex), 1);
        chk("lu_fwd1",   32'(fwd_sel_rs), 1);
        tick();
        mid();
        chk("lu_go",     32'(stall), 0);
        chk("lu_fwd2",   32'(fwd_sel_rs), 2);
        tick();
        idle();
        repeat (5) tick();

        // Youngest priority: MEM r5 (tnew 3), EX r5 (tnew 0)
        producer(5'd5, 3'd5);
        tick();
        producer(5'd5, 3'd1);
        tick();
        idle();
        id_valid = 1'b1;
        id_rs = 5'd5;
        id_tuse_rs = 3'd0;
        id_rt = 5'd5;
        id_tuse_rt = 3'd0;
        mid();
        chk("yp_stall",  32'(stall), 0);
        chk("yp_fwd_rs", 32'(fwd_sel_rs), 1);
        chk("yp_fwd_rt", 32'(fwd_sel_rt), 1);
        tick();
        idle();
        repeat (5) tick();

        // MD busy: div then mflo
        idle();
        id_valid = 1'b1;
        id_is_md = 1'b1;
        id_md_start = 1'b1;
        id_md_div = 1'b1;
        mid();
        chk("md_idle", 32'(md_busy), 0);
        tick();
        producer(5'd2, 3'd1);
        id_is_md = 1'b1;
        for (int i = 1; i <= DL; i++) begin
            mid();
            chk("md_stall", 32'(stall), 1);
            chk("md_busy",  32'(md_busy), 1);
            tick();
        end
        mid();
        chk("md_pass",  32'(stall), 0);
        chk("md_done",  32'(md_busy), 0);
        tick();
        idle();
        repeat (5) tick();

        // Flush collides with a load-use stall
        producer(5'd8, 3'd3);
        tick();
        idle();
        id_valid = 1'b1;
        id_rs = 5'd8;
        id_tuse_rs = 3'd0;
        flush_req = 1'b1;
        mid();
        chk("fl_stall", 32'(stall), 0);
        chk("fl_clr_ex", 32'(clr_ex), 1);
        chk("fl_front", 32'(clr_front), 1);
        chk("fl_md_dis", 32'(md_dis), 1);
        tick();
        flush_req = 1'b0;
        mid();
        chk("fl_fwd", 32'(fwd_sel_rs), 0);
        chk("fl_after", 32'(stall), 0);
        tick();
        idle();
        repeat (5) tick();

        // Consumer not valid never stalls
        producer(5'd8, 3'd3);
        tick();
        idle();
        id_rs = 5'd8;
        id_tuse_rs = 3'd1;
        mid();
        chk("nv_stall", 32'(stall), 0);
        chk("nv_clr_ex", 32'(clr_ex), 0);
        tick();
        repeat (5) tick();

        // Reset mid-multiply
        idle();
        id_valid = 1'b1;
        id_is_md = 1'b1;
        id_md_start = 1'b1;
        tick();
        idle();
        mid();
        chk("rm_busy", 32'(md_busy), 1);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rm_busy0",  32'(md_busy), 0);
        chk("rm_stall",  32'(stall), 0);
        chk("rm_clr_ex", 32'(clr_ex), 0);
        chk("rm_front",  32'(clr_front), 0);
        tick();
        reset_n = 1'b1;
        producer(5'd3, 3'd1);
        id_is_md = 1'b1;
        mid();
        chk("rm_mfhi", 32'(stall), 0);
        chk("rm_idle", 32'(md_busy), 0);
        tick();
        idle();
        repeat (5) tick();

        // Register zero never matches
        producer(5'd0, 3'd2);
        tick();
        idle();
        id_valid = 1'b1;
        id_tuse_rs = 3'd0;
        id_tuse_rt = 3'd0;
        mid();
        chk("z_stall", 32'(stall), 0);
        chk("z_fwd",   32'(fwd_sel_rs), 0);
        tick();
        idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
